// File: rtl/cas_pkg.sv
// Shared types for the cassette tape player.
// Holds the player state encoding and the audio monitor level.
// No logic, no ports.
package cas_pkg;

  // Player states, in playback order.
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CLK_P,
    GAP1,
    DATA_P,
    GAP2,
    DONE
  } play_state_e;

  // Level mixed into the audio path while a pulse is on tape.
  localparam logic [7:0] AUDIO_LVL = 8'h60;

endpackage

// File: rtl/cas_buf_ram.sv
// Purpose : simple dual-port byte buffer holding the downloaded .CAS image.
// Latency : write lands on the clock edge; read data is registered, 1 cycle after rd_addr.
// Backpr. : none; both ports accept an access every cycle.
// Ports   : clk_sys; wr_en/wr_addr/wr_data write port; rd_addr -> rd_data read port.
module cas_buf_ram #(
  parameter int ADDR_W = 14
) (
  input  logic              clk_sys,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cas_tape_player.sv
// Purpose : buffers a .CAS image from the ioctl download and replays it as a 500-baud
//           TRS-80 pulse train (clock pulse at cell start, data pulse at mid-cell if bit=1).
// Latency : first clock pulse 2 cycles after motor is seen in IDLE; cells exactly CELL_CYC apart.
// Backpr. : motor low freezes playback in place; an active cassette download holds the player idle.
// Ports   : clk_sys, reset (sync, active high); dn_go/dn_wr/dn_addr/dn_data/dn_idx download port;
//           motor, rewind controls; tape_pulse/tape_busy/tape_end status; cas_len buffer fill.
// Config  : CAS_TAPE_AUDIO_EN adds registered output tape_audio (AUDIO_LVL while tape_pulse).
module cas_tape_player
  import cas_pkg::*;
#(
  parameter int          ADDR_W    = 14,
  parameter logic [7:0]  CAS_IDX   = 8'd1,
  parameter int          CELL_CYC  = 7000,
  parameter int          PULSE_CYC = 437
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dn_go,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [7:0]        dn_data,
  input  logic [7:0]        dn_idx,
  input  logic              motor,
  input  logic              rewind,
  output logic              tape_pulse,
  output logic              tape_busy,
  output logic              tape_end,
  output logic [ADDR_W:0]   cas_len
`ifdef CAS_TAPE_AUDIO_EN
  ,
  output logic [7:0]        tape_audio
`endif
);

  localparam int OFFS_W = $clog2(CELL_CYC);
  localparam logic [OFFS_W-1:0] OFF_LAST     = OFFS_W'(CELL_CYC - 1);
  localparam logic [OFFS_W-1:0] OFF_FETCH    = OFFS_W'(CELL_CYC - 2);
  localparam logic [OFFS_W-1:0] OFF_PRE      = OFFS_W'(CELL_CYC - 3);
  localparam logic [OFFS_W-1:0] OFF_CLK_END  = OFFS_W'(PULSE_CYC - 1);
  localparam logic [OFFS_W-1:0] OFF_GAP1_END = OFFS_W'(CELL_CYC / 2 - 1);
  localparam logic [OFFS_W-1:0] OFF_DATA_END = OFFS_W'(CELL_CYC / 2 + PULSE_CYC - 1);

  play_state_e       state, state_nxt;
  logic [OFFS_W-1:0] offs, offs_nxt, offs_inc;
  logic [2:0]        bit_idx, bit_nxt;
  logic [ADDR_W:0]   ptr, ptr_nxt, ptr_inc;
  logic [7:0]        sreg, rd_data;
  logic              end_nxt, load_sreg, pulse_nxt;
  logic              sel, sel_q, sel_rise;
  logic [ADDR_W:0]   wr_len, len_base;

  assign sel      = dn_go && (dn_idx == CAS_IDX);
  assign sel_rise = sel && !sel_q;
  assign wr_len   = {1'b0, dn_addr} + (ADDR_W+1)'(1);
  assign len_base = sel_rise ? '0 : cas_len;
  assign offs_inc = (offs == OFF_LAST) ? '0 : offs + OFFS_W'(1);
  assign ptr_inc  = ptr + (ADDR_W+1)'(1);

  cas_buf_ram #(.ADDR_W(ADDR_W)) u_buf (
    .clk_sys (clk_sys),
    .wr_en   (sel && dn_wr),
    .wr_addr (dn_addr),
    .wr_data (dn_data),
    .rd_addr (ptr[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  // Fill length: restarts at 0 with each new cassette download, then tracks the highest byte
  // written. An address of 2^ADDR_W-1 yields exactly 2^ADDR_W, so no explicit clamp is needed.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cas_len <= '0;
      sel_q   <= 1'b0;
    end else begin
      sel_q <= sel;
      if (sel) cas_len <= (dn_wr && wr_len > len_base) ? wr_len : len_base;
    end
  end

  // One offset counter spans the whole cell; the states just mark its phases. Entering FETCH
  // preloads the offset to CELL_CYC-2 so the 2-cycle fetch ends exactly on a cell boundary.
  always_comb begin
    state_nxt = state;
    offs_nxt  = offs;
    bit_nxt   = bit_idx;
    ptr_nxt   = ptr;
    end_nxt   = tape_end;
    load_sreg = 1'b0;
    if (sel_rise || rewind) begin
      state_nxt = IDLE;
      ptr_nxt   = '0;
      end_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (motor && cas_len != '0 && !sel) begin
            state_nxt = FETCH;
            offs_nxt  = OFF_FETCH;
          end
        end
        DONE: end_nxt = 1'b1;
        default: begin
          if (motor) begin
            offs_nxt = offs_inc;
            case (state)
              FETCH: begin
                bit_nxt = 3'd7;
                if (offs == OFF_LAST) begin
                  state_nxt = CLK_P;
                  load_sreg = 1'b1;
                end
              end
              CLK_P:  if (offs == OFF_CLK_END)  state_nxt = GAP1;
              GAP1:   if (offs == OFF_GAP1_END) state_nxt = DATA_P;
              DATA_P: if (offs == OFF_DATA_END) state_nxt = GAP2;
              GAP2: begin
                if (bit_idx != 3'd0) begin
                  if (offs == OFF_LAST) begin
                    state_nxt = CLK_P;
                    bit_nxt   = bit_idx - 3'd1;
                  end
                end else if (ptr_inc >= cas_len) begin
                  if (offs == OFF_LAST) begin
                    state_nxt = DONE;
                    ptr_nxt   = ptr_inc;
                    end_nxt   = 1'b1;
                  end
                end else if (offs == OFF_PRE) begin
                  // Prefetch the next byte inside the last two cycles of this cell.
                  state_nxt = FETCH;
                  ptr_nxt   = ptr_inc;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // Pulse level follows the next state, so a frozen state also freezes the pulse.
  assign pulse_nxt = (state_nxt == CLK_P) || (state_nxt == DATA_P && sreg[bit_idx]);
  assign tape_busy = (state != IDLE) && (state != DONE);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      offs       <= '0;
      bit_idx    <= 3'd7;
      ptr        <= '0;
      sreg       <= '0;
      tape_end   <= 1'b0;
      tape_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      offs       <= offs_nxt;
      bit_idx    <= bit_nxt;
      ptr        <= ptr_nxt;
      tape_end   <= end_nxt;
      tape_pulse <= pulse_nxt;
      if (load_sreg) sreg <= rd_data;
    end
  end

`ifdef CAS_TAPE_AUDIO_EN
  always_ff @(posedge clk_sys) begin
    if (reset) tape_audio <= 8'h00;
    else       tape_audio <= pulse_nxt ? AUDIO_LVL : 8'h00;
  end
`endif

endmodule

// File: tb/tb_cas_tape_player.sv
// Bench for cas_tape_player with small cell timing (CELL=16, PULSE=2, CAS_IDX=1).
// Expected waveform is derived from cell arithmetic over the downloaded image.
// Motor freeze is modelled by counting only clock edges that see motor high.
module tb_cas_tape_player;

  localparam int ADDR_W = 8;
  localparam int CELL   = 16;
  localparam int PULSE  = 2;
  localparam logic [7:0] CAS_IDX = 8'd1;

  logic              clk_sys = 1'b0;
  logic              reset, dn_go, dn_wr, motor, rewind;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data, dn_idx;
  logic              tape_pulse, tape_busy, tape_end;
  logic [ADDR_W:0]   cas_len;
`ifdef CAS_TAPE_AUDIO_EN
  logic [7:0]        tape_audio;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int exp_len  = 0;
  logic [7:0] mem_model [0:255];
  logic [7:0] dl_data   [0:255];

  always #5 clk_sys = ~clk_sys;

  cas_tape_player #(
    .ADDR_W(ADDR_W), .CAS_IDX(CAS_IDX), .CELL_CYC(CELL), .PULSE_CYC(PULSE)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .dn_go(dn_go), .dn_wr(dn_wr), .dn_addr(dn_addr),
    .dn_data(dn_data), .dn_idx(dn_idx), .motor(motor), .rewind(rewind),
    .tape_pulse(tape_pulse), .tape_busy(tape_busy), .tape_end(tape_end), .cas_len(cas_len)
`ifdef CAS_TAPE_AUDIO_EN
    , .tape_audio(tape_audio)
`endif
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected pulse level k cycles after the first clock pulse of an unbroken run.
  function automatic bit m_pulse(input int k);
    int c, o;
    if (k < 0 || k >= CELL * 8 * exp_len) return 1'b0;
    c = k / CELL;
    o = k % CELL;
    if (o < PULSE) return 1'b1;
    if (o >= CELL / 2 && o < CELL / 2 + PULSE) return mem_model[c / 8][7 - (c % 8)];
    return 1'b0;
  endfunction

  task automatic download(input logic [7:0] idx, input int n, input bit reverse,
                          input int rew_at, input int base);
    int a;
    dn_go = 1'b1; dn_idx = idx;
    tick();
    if (idx == CAS_IDX) exp_len = 0;
    for (int i = 0; i < n; i++) begin
      a = base + (reverse ? n - 1 - i : i);
      dn_wr = 1'b1; dn_addr = a[ADDR_W-1:0]; dn_data = dl_data[a - base];
      rewind = (i == rew_at);
      tick();
      if (idx == CAS_IDX) begin
        mem_model[a] = dl_data[a - base];
        if (a + 1 > exp_len) exp_len = a + 1;
      end
    end
    dn_wr = 1'b0; rewind = 1'b0;
    tick();
    dn_go = 1'b0; dn_idx = 8'd0;
    tick();
    chk("cas_len", 32'(cas_len), 32'(exp_len));
  endtask

  // Run with motor on; stop early at offset stop_k (if >= 0); drop motor for 20 cycles at drop_k.
  task automatic play(input int stop_k, input int drop_k);
    int v, k, total, budget, drop_left, clk_rise, dat_rise, exp_dat;
    logic prev;
    total = CELL * 8 * exp_len;
    budget = total + 60;
    v = 0; k = -3; drop_left = 0; clk_rise = 0; dat_rise = 0; exp_dat = 0; prev = 1'b0;
    motor = 1'b1;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (motor) v++;
      k = v - 3;
      chk("pulse", 32'(tape_pulse), 32'(m_pulse(k)));
      chk("busy", 32'(tape_busy), 32'(exp_len != 0 && v >= 1 && k < total));
      chk("end", 32'(tape_end), 32'(exp_len != 0 && k >= total));
`ifdef CAS_TAPE_AUDIO_EN
      chk("audio", 32'(tape_audio), m_pulse(k) ? 32'h60 : 32'h0);
`endif
      if (tape_pulse && !prev) begin
        if ((k % CELL) == 0) clk_rise++;
        else dat_rise++;
      end
      prev = tape_pulse;
      if (drop_left > 0) begin
        drop_left--;
        motor = (drop_left == 0);
      end else if (k == drop_k && motor) begin
        motor = 1'b0;
        drop_left = 20;
      end
      if (stop_k >= 0 && k == stop_k) break;
    end
    motor = 1'b0;
    if (stop_k < 0) begin
      for (int i = 0; i < exp_len; i++) exp_dat += $countones(mem_model[i]);
      chk("clk_pulses", 32'(clk_rise), 32'(8 * exp_len));
      chk("data_pulses", 32'(dat_rise), 32'(exp_dat));
    end
  endtask

  task automatic do_rewind();
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    chk("rew_pulse", 32'(tape_pulse), 32'd0);
    chk("rew_busy", 32'(tape_busy), 32'd0);
    chk("rew_end", 32'(tape_end), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; dn_go = 1'b0; dn_wr = 1'b0; motor = 1'b0; rewind = 1'b0;
    dn_addr = '0; dn_data = 8'h00; dn_idx = 8'h00;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    tick(); tick(); tick();
    chk("rst_pulse", 32'(tape_pulse), 32'd0);
    chk("rst_busy", 32'(tape_busy), 32'd0);
    chk("rst_end", 32'(tape_end), 32'd0);
    chk("rst_len", 32'(cas_len), 32'd0);
    reset = 1'b0;
    tick();

    // Directed image, then an ignored download on another index.
    dl_data[0] = 8'hA5; dl_data[1] = 8'h00; dl_data[2] = 8'hFF;
    download(8'd1, 3, 1'b0, -1, 0);
    dl_data[0] = 8'h11; dl_data[1] = 8'h22; dl_data[2] = 8'h33; dl_data[3] = 8'h44;
    download(8'd0, 4, 1'b0, -1, 0);

    play(-1, -1);
    do_rewind();
    play(-1, 3 * CELL + 5);
    do_rewind();
    play(8 * CELL + 20, -1);
    do_rewind();
    play(-1, -1);

    // Random image, written in random order, with a rewind on a write cycle.
    n = $urandom_range(5, 8);
    for (int i = 0; i < n; i++) dl_data[i] = 8'($urandom);
    download(8'd1, n, 1'($urandom % 2), 1, 0);
    play(-1, $urandom_range(0, 8 * n * CELL - 1));

    // Reset mid-play: buffer length lost, motor produces nothing.
    do_rewind();
    play(30, -1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_len = 0;
    chk("rst2_len", 32'(cas_len), 32'd0);
    chk("rst2_pulse", 32'(tape_pulse), 32'd0);
    chk("rst2_busy", 32'(tape_busy), 32'd0);
    play(-1, -1);

    // Length saturates at buffer size; a new download restarts it.
    dl_data[0] = 8'h5A;
    download(8'd1, 1, 1'b0, -1, 255);
    dl_data[0] = 8'h81; dl_data[1] = 8'h7E;
    download(8'd1, 2, 1'b0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
